// File: rtl/cprs_7_2.sv
// rtl/cprs_7_2.sv - 7:2 column compressor built from five full adders.
// Define CPRS_OUTREG_EN to register out/yo; otherwise the block is combinational.
module cprs_7_2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] in,
    input  logic [3:0] yi,
    output logic [1:0] out,
    output logic [3:0] yo
);

    logic s0, s1, s2, s3;
    logic [3:0] yo_c;
    logic [1:0] out_c;

    // First tier: FA0 and FA1 only see operand bits, so yo[1:0] has no yi path
    assign s0      = in[0] ^ in[1] ^ in[2];
    assign yo_c[0] = (in[0] & in[1]) | (in[0] & in[2]) | (in[1] & in[2]);
    assign s1      = in[3] ^ in[4] ^ in[5];
    assign yo_c[1] = (in[3] & in[4]) | (in[3] & in[5]) | (in[4] & in[5]);

    assign s2      = s0 ^ s1 ^ in[6];
    assign yo_c[2] = (s0 & s1) | (s0 & in[6]) | (s1 & in[6]);

    assign s3      = s2 ^ yi[0] ^ yi[1];
    assign yo_c[3] = (s2 & yi[0]) | (s2 & yi[1]) | (yi[0] & yi[1]);

    // Last FA absorbs yi[3:2] and feeds only out, never yo
    assign out_c[0] = s3 ^ yi[2] ^ yi[3];
    assign out_c[1] = (s3 & yi[2]) | (s3 & yi[3]) | (yi[2] & yi[3]);

`ifdef CPRS_OUTREG_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out <= 2'b00;
            yo  <= 4'b0000;
        end else begin
            out <= out_c;
            yo  <= yo_c;
        end
    end
`else
    logic unused_clk_rstn;
    assign unused_clk_rstn = clk ^ rstn;
    assign out = out_c;
    assign yo  = yo_c;
`endif

endmodule

// File: tb/tb_cprs_7_2.sv
// tb/tb_cprs_7_2.sv - self-checking bench for cprs_7_2 (both CPRS_OUTREG_EN builds).
module tb_cprs_7_2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] in = 7'd0;
    logic [3:0] yi = 4'd0;
    logic [1:0] out;
    logic [3:0] yo;

    int n_tests = 0;
    int n_fail  = 0;

    cprs_7_2 dut (
        .clk  (clk),
        .rstn (rstn),
        .in   (in),
        .yi   (yi),
        .out  (out),
        .yo   (yo)
    );

    always #5 clk = ~clk;

    function automatic int cnt3(logic a, logic b, logic c);
        return int'(a) + int'(b) + int'(c);
    endfunction

    // Each FA counts ones: sum = count mod 2, carry = count div 2. Returns {yo, out}.
    function automatic logic [5:0] model(logic [6:0] a, logic [3:0] y);
        int c0, c1, c2, c3, c4;
        logic [3:0] m_yo;
        logic [1:0] m_out;
        c0 = cnt3(a[0], a[1], a[2]);
        c1 = cnt3(a[3], a[4], a[5]);
        c2 = (c0 % 2) + (c1 % 2) + int'(a[6]);
        c3 = (c2 % 2) + int'(y[0]) + int'(y[1]);
        c4 = (c3 % 2) + int'(y[2]) + int'(y[3]);
        m_yo  = {c3 >= 2, c2 >= 2, c1 >= 2, c0 >= 2};
        m_out = {c4 >= 2, (c4 % 2) == 1};
        return {m_yo, m_out};
    endfunction

    function automatic int popc(logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(v[i]);
        return n;
    endfunction

    logic [5:0] exp_reg = 6'd0;
    logic [6:0] exp_in  = 7'd0;
    logic [3:0] exp_yi  = 4'd0;
    logic       exp_rst = 1'b1;
    logic       valid   = 1'b0;

`ifdef CPRS_OUTREG_EN
    always @(posedge clk) begin
        exp_rst <= !rstn;
        exp_in  <= in;
        exp_yi  <= yi;
        exp_reg <= rstn ? model(in, yi) : 6'd0;
        valid   <= 1'b1;
    end
`endif

    // Compare process: outputs checked every cycle at the falling edge
    always @(negedge clk) begin
        logic [5:0] e;
        logic [6:0] ci;
        logic [3:0] cy;
`ifdef CPRS_OUTREG_EN
        e = exp_reg; ci = exp_in; cy = exp_yi;
        if (valid) begin
`else
        e = model(in, yi); ci = in; cy = yi;
        begin
`endif
            n_tests++;
            if ({yo, out} !== e) begin
                n_fail++;
                $display("FAIL cycle_model in=%b yi=%b: got yo=%b out=%b, want yo=%b out=%b",
                         ci, cy, yo, out, e[5:2], e[1:0]);
            end
`ifdef CPRS_OUTREG_EN
            if (!exp_rst) begin
`else
            begin
`endif
                n_tests++;
                if (popc(ci) + popc({3'b0, cy}) !==
                    int'(out[0]) + 2 * int'(out[1]) + 2 * popc({3'b0, yo})) begin
                    n_fail++;
                    $display("FAIL invariant in=%b yi=%b: got out=%b yo=%b", ci, cy, out, yo);
                end
            end
        end
    end

    task automatic drive(input logic [6:0] a, input logic [3:0] y, input logic r);
        @(posedge clk);
        #1;
        in = a; yi = y; rstn = r;
    endtask

    task automatic lit(input string nm, input logic [6:0] a, input logic [3:0] y,
                       input logic [1:0] eo, input logic [3:0] ey);
        drive(a, y, 1'b1);
        @(negedge clk);
`ifdef CPRS_OUTREG_EN
        @(posedge clk);
        #1;
`endif
        n_tests++;
        if (out !== eo || yo !== ey) begin
            n_fail++;
            $display("FAIL %s: got out=%b yo=%b, want out=%b yo=%b", nm, out, yo, eo, ey);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
`ifdef CPRS_OUTREG_EN
        n_tests++;
        if (out !== 2'b00 || yo !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got out=%b yo=%b, want out=00 yo=0000", out, yo);
        end
`endif
        lit("vec_zero",   7'b0000000, 4'b0000, 2'b00, 4'b0000);
        lit("vec_one",    7'b0000001, 4'b0000, 2'b01, 4'b0000);
        lit("vec_in_all", 7'b1111111, 4'b0000, 2'b01, 4'b0111);
        lit("vec_yi_all", 7'b0000000, 4'b1111, 2'b10, 4'b1000);
        lit("vec_all",    7'b1111111, 4'b1111, 2'b11, 4'b1111);

        // Exhaustive sweep with one reset pulse in the middle
        for (int v = 0; v < 2048; v++) begin
            logic [10:0] w;
            w = 11'(v);
            drive(w[6:0], w[10:7], v != 1000);
`ifdef CPRS_OUTREG_EN
            if (v == 1000) begin
                @(posedge clk);
                #1;
                n_tests++;
                if (out !== 2'b00 || yo !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL mid_reset: got out=%b yo=%b, want out=00 yo=0000", out, yo);
                end
                rstn = 1'b1;
            end
`endif
        end

        // Random operands with occasional reset
        for (int k = 0; k < 600; k++)
            drive(7'($urandom), 4'($urandom), $urandom_range(0, 15) != 0);

        drive(7'd0, 4'd0, 1'b1);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cprs_7_2.md
CPRS_7_2 -- requirements
Module: cprs_7_2

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  clock; rising edge is the active edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 in  input  7  column operand bits, weight 1 each, in[6:0].
REQ-005 yi  input  4  carry-ins from the lower-column compressor, weight 1 each, yi[3:0].
REQ-006 out  output  2  out[0] = sum (weight 1); out[1] = carry (weight 2).
REQ-007 yo  output  4  carry-outs to the higher-column compressor, weight 2 each, yo[3:0].

Function
REQ-008 The core SHALL be built from five full adders (FA: s = a^b^c, co = majority(a,b,c)), connected as below.
REQ-009 FA0: inputs (in[0], in[1], in[2]); outputs s0 and yo[0].
REQ-010 FA1: inputs (in[3], in[4], in[5]); outputs s1 and yo[1].
REQ-011 FA2: inputs (s0, s1, in[6]); outputs s2 and yo[2].
REQ-012 FA3: inputs (s2, yi[0], yi[1]); outputs s3 and yo[3].
REQ-013 FA4: inputs (s3, yi[2], yi[3]); outputs out[0] and out[1].
REQ-014 Invariant for every input combination: popcount(in) + popcount(yi) = out[0] + 2*out[1] + 2*popcount(yo).
REQ-015 yo[2:0] SHALL depend only on in; yo[3] SHALL depend only on in, yi[0] and yi[1]; no ripple from yi[3:2] into yo.
REQ-016 All 2048 input combinations are legal; there are no don't-care states.
REQ-017 No handshake exists; a new operand is accepted every cycle.

Reset
REQ-018 With CPRS_OUTREG_EN defined: when rstn=0 at a rising clk edge, out SHALL become 2'b00 and yo SHALL become 4'b0000.
REQ-019 Reset SHALL take priority over any data capture on the same edge.
REQ-020 If reset is asserted during operation, the result in flight is discarded.
REQ-021 The first valid result appears one edge after rstn is sampled high.
REQ-022 Without CPRS_OUTREG_EN: rstn and clk SHALL have no effect on the outputs.

Configuration
REQ-023 Macro CPRS_OUTREG_EN defined: out and yo SHALL be registered on the rising clk edge.
- Latency: 1 cycle from in/yi to out/yo.
- Throughput: 1 result per cycle.
REQ-024 Macro CPRS_OUTREG_EN undefined: out and yo SHALL be purely combinational from in/yi.
- Latency: 0.
- clk and rstn remain ports but are unused.

Verification
REQ-025 in=7'b0000000, yi=4'b0000 -> out=2'b00, yo=4'b0000.
REQ-026 in=7'b0000001, yi=4'b0000 -> out=2'b01, yo=4'b0000.
REQ-027 in=7'b1111111, yi=4'b0000 -> out=2'b01, yo=4'b0111.
REQ-028 in=7'b0000000, yi=4'b1111 -> out=2'b10, yo=4'b1000.
REQ-029 in=7'b1111111, yi=4'b1111 -> out=2'b11, yo=4'b1111.
REQ-030 Exhaustive counter sweep of {yi,in} from 0 to 2047 -> REQ-014 holds for every value.
- With CPRS_OUTREG_EN: each result is checked one cycle later.
- With CPRS_OUTREG_EN: rstn=0 mid-sweep gives all-zero outputs on the next edge.
